// File: rtl/pipeline_gstall_top.sv
// -----------------------------------------------------------------------------
// pipeline_gstall_top
//
// Valid/data pipeline feeding an output FIFO that drains to a shared resource
// through a req/grant handshake. One global stall freezes the whole pipeline
// (and tells upstream to hold) whenever the FIFO cannot take another word.
//
// Parameters
//   DATA_W     word width
//   STAGES     pipeline register stages (>= 1)
//   BUF_DEPTH  FIFO slots (>= 2, power of two)
//   STALL_REG  0: stall = full && !pop (combinational)
//              1: registered stall raised at BUF_DEPTH-1 entries (one-slot margin)
//   RES_LAT    cycles from a pop to the resource result being valid (>= 0)
//   CNT_W      width of the saturating stall-cycle counter
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   inputs/in_valid  upstream word; upstream holds both while stall_signal=1
//   flush            synchronous clear of pipeline, FIFO, stall and out_valid tracking
//   arbiter_grant    grant for the current request
//   resource_output  result returned by the shared resource
//   outputs          resource_output passed straight through
//   out_valid        outputs valid this cycle (pop delayed by RES_LAT)
//   arbiter_req      request to the arbiter (FIFO not empty)
//   resource_input   FIFO head word
//   stall_signal     global stall to upstream and the pipeline
//   occupancy        FIFO entry count
//   stall_cycles     saturating count of cycles with stall_signal=1
// -----------------------------------------------------------------------------
module pipeline_gstall_top #(
    parameter int DATA_W    = 32,
    parameter int STAGES    = 3,
    parameter int BUF_DEPTH = 4,
    parameter int STALL_REG = 1,
    parameter int RES_LAT   = 1,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          inputs,
    input  logic                       in_valid,
    input  logic                       flush,
    input  logic                       arbiter_grant,
    input  logic [DATA_W-1:0]          resource_output,
    output logic [DATA_W-1:0]          outputs,
    output logic                       out_valid,
    output logic                       arbiter_req,
    output logic [DATA_W-1:0]          resource_input,
    output logic                       stall_signal,
    output logic [$clog2(BUF_DEPTH):0] occupancy,
    output logic [CNT_W-1:0]           stall_cycles
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0] FULL_OCC   = OCC_W'(BUF_DEPTH);
    localparam logic [OCC_W-1:0] MARGIN_OCC = OCC_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    // -------------------------------------------------------------------------
    // Handshake terms
    // -------------------------------------------------------------------------
    logic             accept;
    logic             push;
    logic             pop;
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [STAGES-1:0] stg_valid_q, stg_valid_d;
    logic [DATA_W-1:0] stg_data_q [STAGES];

    assign accept      = in_valid && !stall_signal;
    assign push        = stg_valid_q[STAGES-1] && !stall_signal && !flush;
    // The request can only fall through a pop or a flush, so once raised it
    // stays up until granted and the head word cannot change underneath it.
    assign arbiter_req = (occ_q != '0) && !flush;
    assign pop         = arbiter_req && arbiter_grant && !flush;

    // -------------------------------------------------------------------------
    // Pipeline stages
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        stg_valid_d = stg_valid_q;
        if (flush) begin
            stg_valid_d = '0;
        end else if (!stall_signal) begin
            stg_valid_d[0] = accept;
            for (int k = 1; k < STAGES; k++) begin
                stg_valid_d[k] = stg_valid_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its inputs from before the edge, independent of block order.
        if (!reset) begin
            stg_valid_q <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
        end
    end

    // NOTE: data-path storage has no reset; each word is qualified by its
    // valid bit (or by the FIFO pointers), so its reset value is never seen.
    always_ff @(posedge clk) begin
        if (!stall_signal) begin
            stg_data_q[0] <= inputs;
            for (int k = 1; k < STAGES; k++) begin
                stg_data_q[k] <= stg_data_q[k-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output FIFO
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] fifo_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            // Power-of-two depth: pointers wrap by plain overflow.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= stg_data_q[STAGES-1];
        end
    end

    assign resource_input = fifo_mem[rd_ptr_q];
    assign occupancy      = occ_q;

    // -------------------------------------------------------------------------
    // Global stall
    // -------------------------------------------------------------------------
    generate
        if (STALL_REG != 0) begin : g_stall_reg
            logic stall_q, stall_d;

            // Raised one slot early: while stall_q is low the FIFO holds at
            // most BUF_DEPTH-2 words at the previous edge, so the single push
            // that can slip through before the stall lands always fits.
            assign stall_d = !flush && (occ_d >= MARGIN_OCC);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    stall_q <= 1'b0;
                end else begin
                    stall_q <= stall_d;
                end
            end

            assign stall_signal = stall_q;
        end else begin : g_stall_comb
            // A pop in the same cycle frees a slot, so a push can go in at full.
            assign stall_signal = (occ_q == FULL_OCC) && !pop;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Result-valid alignment to the resource latency
    // -------------------------------------------------------------------------
    generate
        if (RES_LAT == 0) begin : g_lat_none
            assign out_valid = pop;
        end else begin : g_lat_shift
            logic [RES_LAT-1:0] lat_q, lat_d;

            always_comb begin
                lat_d = '0;
                if (!flush) begin
                    lat_d[0] = pop;
                    for (int k = 1; k < RES_LAT; k++) begin
                        lat_d[k] = lat_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lat_q <= '0;
                end else begin
                    lat_q <= lat_d;
                end
            end

            assign out_valid = lat_q[RES_LAT-1];
        end
    endgenerate

    assign outputs = resource_output;

    // -------------------------------------------------------------------------
    // Stall statistics (not cleared by flush)
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign stall_cnt_d = (stall_signal && (stall_cnt_q != CNT_MAX))
                       ? stall_cnt_q + CNT_W'(1)
                       : stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_gstall_top.sv
// -----------------------------------------------------------------------------
// tb_pipeline_gstall_top
//
// Three instances share one clock:
//   dut_a  defaults (STALL_REG=1, RES_LAT=1)  : streaming, registered stall,
//                                               flush, async reset mid-stream
//   dut_b  STALL_REG=0                        : combinational stall, push+pop at full
//   dut_c  RES_LAT=3, CNT_W=2                 : delayed out_valid, counter saturation
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns later.
// Cycle numbers in each step count from the first driven cycle of that step.
// -----------------------------------------------------------------------------
module tb_pipeline_gstall_top;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int idx;

    // dut_a
    logic        a_rst, a_in_valid, a_flush, a_grant;
    logic [31:0] a_in, a_res_out, a_out, a_res_in;
    logic        a_out_valid, a_req, a_stall;
    logic [2:0]  a_occ;
    logic [15:0] a_scyc;
    // dut_b
    logic        b_rst, b_in_valid, b_flush, b_grant;
    logic [31:0] b_in, b_res_out, b_out, b_res_in;
    logic        b_out_valid, b_req, b_stall;
    logic [2:0]  b_occ;
    logic [15:0] b_scyc;
    // dut_c
    logic        c_rst, c_in_valid, c_flush, c_grant;
    logic [31:0] c_in, c_res_out, c_out, c_res_in;
    logic        c_out_valid, c_req, c_stall;
    logic [2:0]  c_occ;
    logic [1:0]  c_scyc;

    pipeline_gstall_top dut_a (
        .clk(clk), .reset(a_rst), .inputs(a_in), .in_valid(a_in_valid), .flush(a_flush),
        .arbiter_grant(a_grant), .resource_output(a_res_out), .outputs(a_out),
        .out_valid(a_out_valid), .arbiter_req(a_req), .resource_input(a_res_in),
        .stall_signal(a_stall), .occupancy(a_occ), .stall_cycles(a_scyc)
    );

    pipeline_gstall_top #(.STALL_REG(0)) dut_b (
        .clk(clk), .reset(b_rst), .inputs(b_in), .in_valid(b_in_valid), .flush(b_flush),
        .arbiter_grant(b_grant), .resource_output(b_res_out), .outputs(b_out),
        .out_valid(b_out_valid), .arbiter_req(b_req), .resource_input(b_res_in),
        .stall_signal(b_stall), .occupancy(b_occ), .stall_cycles(b_scyc)
    );

    pipeline_gstall_top #(.RES_LAT(3), .CNT_W(2)) dut_c (
        .clk(clk), .reset(c_rst), .inputs(c_in), .in_valid(c_in_valid), .flush(c_flush),
        .arbiter_grant(c_grant), .resource_output(c_res_out), .outputs(c_out),
        .out_valid(c_out_valid), .arbiter_req(c_req), .resource_input(c_res_in),
        .stall_signal(c_stall), .occupancy(c_occ), .stall_cycles(c_scyc)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // No pop from an empty FIFO, no occupancy beyond the depth.
    task automatic inv_a();
        check("a_occ_bound", a_occ <= 3'd4, 1'b1);
        check("a_pop_empty", a_req && a_grant && (a_occ == 3'd0), 1'b0);
    endtask
    task automatic inv_b();
        check("b_occ_bound", b_occ <= 3'd4, 1'b1);
        check("b_pop_empty", b_req && b_grant && (b_occ == 3'd0), 1'b0);
    endtask
    task automatic inv_c();
        check("c_occ_bound", c_occ <= 3'd4, 1'b1);
        check("c_pop_empty", c_req && c_grant && (c_occ == 3'd0), 1'b0);
    endtask

    // Registered stall, grant held low until cycle 10 (steps 2 and 6).
    function automatic int occ_reg_stall(int c);
        if (c < 4)   return 0;
        if (c == 4)  return 1;
        if (c == 5)  return 2;
        if (c <= 10) return 3;
        if (c <= 16) return 2;
        if (c == 17) return 1;
        return 0;
    endfunction

    // Combinational stall, grant held low until cycle 10 (step 3).
    function automatic int occ_comb_stall(int c);
        if (c < 4)   return 0;
        if (c == 4)  return 1;
        if (c == 5)  return 2;
        if (c == 6)  return 3;
        if (c <= 14) return 4;
        if (c == 15) return 3;
        if (c == 16) return 2;
        if (c == 17) return 1;
        return 0;
    endfunction

    function automatic int scyc_sat(int c);
        if (c <= 6) return 0;
        if (c == 7) return 1;
        if (c == 8) return 2;
        return 3;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
        a_in_valid = 1'b0; a_flush = 1'b0; a_grant = 1'b0; a_in = '0; a_res_out = '0;
        b_in_valid = 1'b0; b_flush = 1'b0; b_grant = 1'b0; b_in = '0; b_res_out = '0;
        c_in_valid = 1'b0; c_flush = 1'b0; c_grant = 1'b0; c_in = '0; c_res_out = '0;

        // ---------------- reset state ----------------
        #12;
        check("rst_occ",       a_occ, 0);
        check("rst_req",       a_req, 0);
        check("rst_stall",     a_stall, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_scyc",      a_scyc, 0);
        check("rst_b_occ",     b_occ, 0);
        check("rst_c_scyc",    c_scyc, 0);
        #10;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;

        // ---------------- 1: free-flowing stream ----------------
        for (int c = 0; c < 14; c++) begin
            next_cycle();
            a_in_valid = (c < 8);
            a_in       = 32'h10 + c;
            a_grant    = 1'b1;
            a_res_out  = 32'hC0DE_0000 + c;
            #1;
            check("t1_stall", a_stall, 0);
            check("t1_occ",   a_occ, (c >= 4 && c <= 11) ? 1 : 0);
            check("t1_req",   a_req, (c >= 4 && c <= 11));
            if (c >= 4 && c <= 11) check("t1_res_in", a_res_in, 32'h10 + c - 4);
            check("t1_out_valid", a_out_valid, (c >= 5 && c <= 12));
            check("t1_outputs",   a_out, a_res_out);
            inv_a();
        end

        // ---------------- 2: registered stall, grant withheld ----------------
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            a_in_valid = (idx < 8);
            a_in       = 32'h20 + idx;
            a_grant    = (c >= 10);
            #1;
            check("t2_stall", a_stall, (c >= 6 && c <= 10));
            check("t2_occ",   a_occ, occ_reg_stall(c));
            if (c >= 4 && c < 10)  check("t2_res_hold", a_res_in, 32'h20);
            if (c >= 10 && c <= 17) begin
                check("t2_res_in", a_res_in, 32'h20 + c - 10);
                check("t2_req",    a_req, 1);
            end
            check("t2_out_valid", a_out_valid, (c >= 11 && c <= 18));
            inv_a();
            if (a_in_valid && !a_stall) idx++;
        end
        check("t2_accepted", idx, 8);
        check("t2_scyc", a_scyc, 5);

        // ---------------- 3: combinational stall ----------------
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            b_in_valid = (idx < 8);
            b_in       = 32'h30 + idx;
            b_grant    = (c >= 10);
            #1;
            check("t3_stall", b_stall, (c >= 7 && c <= 9));
            check("t3_occ",   b_occ, occ_comb_stall(c));
            if (c >= 4 && c < 10)  check("t3_res_hold", b_res_in, 32'h30);
            if (c >= 10 && c <= 17) check("t3_res_in", b_res_in, 32'h30 + c - 10);
            check("t3_out_valid", b_out_valid, (c >= 11 && c <= 18));
            inv_b();
            if (b_in_valid && !b_stall) idx++;
        end
        check("t3_accepted", idx, 8);
        check("t3_scyc", b_scyc, 3);

        // ---------------- 4: flush with FIFO at 3 and 2 stages in flight ----------------
        for (int c = 0; c < 13; c++) begin
            next_cycle();
            a_in_valid = (c < 5) || (c == 7);
            a_in       = (c == 7) ? 32'hAA : 32'h40 + c;
            a_flush    = (c == 6);
            a_grant    = (c >= 6);
            #1;
            if (c == 5) check("t4_pre_stall", a_stall, 0);
            if (c == 6) begin
                check("t4_pre_occ",   a_occ, 3);
                check("t4_pre_stall_hi", a_stall, 1);
                check("t4_req_flush", a_req, 0);
            end
            if (c >= 7 && c <= 10) begin
                check("t4_occ",       a_occ, 0);
                check("t4_req",       a_req, 0);
                check("t4_out_valid", a_out_valid, 0);
                check("t4_stall",     a_stall, 0);
            end
            if (c == 11) begin
                check("t4_first_pop", a_res_in, 32'hAA);
                check("t4_req_aa",    a_req, 1);
                check("t4_occ_aa",    a_occ, 1);
            end
            if (c == 12) begin
                check("t4_out_valid_aa", a_out_valid, 1);
                check("t4_occ_end",      a_occ, 0);
            end
            inv_a();
        end
        a_flush = 1'b0;
        check("t4_scyc", a_scyc, 6);

        // ---------------- 5: asynchronous reset mid-stream ----------------
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            a_in_valid = 1'b1;
            a_in       = 32'h60 + c;
            a_grant    = 1'b0;
            #1;
        end
        check("t5_pre_occ", a_occ, 2);
        #2;
        a_rst = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check("t5_occ",       a_occ, 0);
        check("t5_req",       a_req, 0);
        check("t5_stall",     a_stall, 0);
        check("t5_out_valid", a_out_valid, 0);
        check("t5_scyc",      a_scyc, 0);
        #1;
        a_rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            a_in_valid = (c == 0);
            a_in       = 32'h55;
            a_grant    = 1'b1;
            #1;
            check("t5_lat_occ", a_occ, (c == 4) ? 1 : 0);
            check("t5_lat_req", a_req, (c == 4));
            if (c == 4) check("t5_res_in", a_res_in, 32'h55);
            check("t5_lat_out_valid", a_out_valid, (c == 5));
            inv_a();
        end

        // ---------------- 6: RES_LAT=3, 2-bit stall counter ----------------
        idx = 0;
        for (int c = 0; c < 23; c++) begin
            next_cycle();
            c_in_valid = (idx < 8);
            c_in       = 32'h70 + idx;
            c_grant    = (c >= 10);
            #1;
            check("t6_stall", c_stall, (c >= 6 && c <= 10));
            check("t6_occ",   c_occ, occ_reg_stall(c));
            if (c >= 10 && c <= 17) check("t6_res_in", c_res_in, 32'h70 + c - 10);
            check("t6_out_valid", c_out_valid, (c >= 13 && c <= 20));
            check("t6_scyc", c_scyc, scyc_sat(c));
            inv_c();
            if (c_in_valid && !c_stall) idx++;
        end
        check("t6_accepted", idx, 8);

        // Flush while a pop is still inside the latency line: no out_valid.
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            c_in_valid = (c == 0);
            c_in       = 32'h7F;
            c_grant    = 1'b1;
            c_flush    = (c == 5);
            #1;
            if (c == 4) begin
                check("t6f_res_in", c_res_in, 32'h7F);
                check("t6f_req",    c_req, 1);
            end
            check("t6f_out_valid", c_out_valid, 0);
            inv_c();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
